// File: rtl/salamander_pkg.sv
// Shared definitions for the program loader: FSM states, length limit, error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package salamander_pkg;

  // Loader FSM states; the checksum state exists only when PROG_LOADER_CHKSUM_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
`ifdef PROG_LOADER_CHKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERR
  } load_state_t;

  // Largest program the loader accepts (one word per memory location)
  localparam int LOAD_LEN_MAX = 32;

  // err_code values
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_DATA = 2'b10;
  localparam logic [1:0] ERR_CHK  = 2'b11;

endpackage

// File: rtl/prog_loader_chk.sv
// Running XOR of accepted data bytes, used to validate the trailing checksum byte.
// Latency: accumulator reflects a byte one cycle after en; clr wins over en.
// Backpressure: none; updates only when the loader strobes en.
module prog_loader_chk (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  // Accumulate XOR of enabled bytes, restart on clr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    acc <= 8'h00;
    else if (clr) acc <= 8'h00;
    else if (en)  acc <= acc ^ din;
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into program memory, then releases the CPU.
// Latency: memory write strobe one cycle after each accepted data byte; done the cycle after the last strobe.
// Backpressure: in_ready is a function of state only; one byte per cycle while in LEN/DATA/CHK.
// Optional feature: define PROG_LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import salamander_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 cpu_run,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  // Counter is one bit wider than the address so a full 32-word load never wraps
  localparam int CW = ADDR_SIZE + 1;

  load_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] len_q;
  logic [1:0]    err_code_q, err_code_d;
  logic          accept;
  logic          wr_d, cnt_clr, cnt_inc, len_ld;
  logic          len_bad, byte_bad, last_word;

  assign accept    = in_valid && in_ready;
  assign len_bad   = (in_data == 8'd0) || (in_data > 8'(LOAD_LEN_MAX));
  assign byte_bad  = (in_data >> DATA_SIZE) != 8'd0;
  assign last_word = (cnt_q + CW'(1)) == len_q;

`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_en;

  assign chk_en = accept && (state_q == ST_DATA);

  prog_loader_chk u_chk (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .en   (chk_en),
    .din  (in_data),
    .acc  (chk_acc)
  );
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    wr_d       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    len_ld     = 1'b0;
    in_ready   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN;
          cnt_clr    = 1'b1;
          err_code_d = ERR_NONE;
        end
      end
      ST_LEN: begin
        in_ready = 1'b1;
        if (accept) begin
          if (len_bad) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LEN;
          end else begin
            state_d = ST_DATA;
            len_ld  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (accept) begin
          if (byte_bad) begin
            state_d    = ST_ERR;
            err_code_d = ERR_DATA;
          end else begin
            wr_d    = 1'b1;
            cnt_inc = 1'b1;
            if (last_word) begin
`ifdef PROG_LOADER_CHKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
      end
`ifdef PROG_LOADER_CHKSUM_EN
      ST_CHK: begin
        in_ready = 1'b1;
        if (accept) begin
          if (chk_acc == in_data) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CHK;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Word counter, length latch, memory write port and error code
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      len_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      mem_we     <= wr_d;
      err_code_q <= err_code_d;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
      if (len_ld) len_q <= in_data[CW-1:0];
      if (wr_d) begin
        mem_addr  <= cnt_q[ADDR_SIZE-1:0];
        mem_wdata <= in_data[DATA_SIZE-1:0];
      end
    end
  end

  // Completion flags follow the state; done waits out the final write strobe
  assign done     = (state_q == ST_DONE) && !mem_we;
  assign cpu_run  = done;
  assign err      = (state_q == ST_ERR);
  assign err_code = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, cpu_run, done, err;
  logic [4:0] mem_addr;
  logic [5:0] mem_wdata;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_we_cyc = -10;
  logic out_prev = 1'b0;

  logic [10:0] wq [$];   // expected {addr, data}
  logic [1:0]  oq [$];   // expected final err_code (00 = done)

  prog_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derives the outcome of a load from the stream rules alone
  task automatic model(input bq_t q, output int used, output logic [1:0] code);
    int n;
    logic [7:0] x;
    x = 8'h00;
    used = 1;
    n = int'(q[0]);
    if (n == 0 || n > 32) begin
      code = 2'b01;
      return;
    end
    for (int i = 1; i <= n; i++) begin
      used++;
      if (q[i] > 8'd63) begin
        code = 2'b10;
        return;
      end
      wq.push_back({5'(i - 1), q[i][5:0]});
      x = x ^ q[i];
    end
`ifdef PROG_LOADER_CHKSUM_EN
    used++;
    if (q[n + 1] != x) begin
      code = 2'b11;
      return;
    end
`endif
    code = 2'b00;
  endtask

  // Appends the XOR checksum byte when the loader expects one
  task automatic add_chk(inout bq_t q, input logic [7:0] corrupt);
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < q.size(); i++) x = x ^ q[i];
    q.push_back(x ^ corrupt);
`else
    if (corrupt != 8'h00) q = q;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int bound;
    gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = ($urandom_range(0, 7) == 0);   // must be ignored mid-load
    bound = 0;
    while (!in_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_load(input bq_t q, input int max_gap);
    int used;
    int bound;
    logic [1:0] code;
    model(q, used, code);
    oq.push_back(code);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clears", {27'd0, in_ready, done, err, cpu_run, |err_code}, {27'd0, 5'b10000});
    for (int i = 0; i < used; i++) send_byte(q[i], max_gap);
    bound = 0;
    while (oq.size() != 0 && bound < 20) begin
      @(negedge clk);
      bound++;
    end
    check("outcome_seen", oq.size(), 0);
    check("writes_drained", wq.size(), 0);
    oq.delete();
    wq.delete();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Monitor: pops expected writes and outcomes as the DUT presents them
  always @(negedge clk) begin
    logic [10:0] e;
    logic [1:0]  c;
    cyc++;
    if (rstn) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data %h expected none", mem_addr, mem_wdata);
        end else begin
          e = wq.pop_front();
          check("write", {21'd0, mem_addr, mem_wdata}, {21'd0, e});
        end
        check("done_overlaps_we", {31'd0, done}, 32'd0);
        last_we_cyc = cyc;
      end
      if ((done || err) && !out_prev) begin
        if (oq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_outcome: got done %b err %b expected none", done, err);
        end else begin
          c = oq.pop_front();
          if (c == 2'b00) begin
            check("outcome", {27'd0, done, err, cpu_run, err_code}, {27'd0, 5'b10100});
`ifndef PROG_LOADER_CHKSUM_EN
            check("done_latency", cyc, last_we_cyc + 1);
`endif
          end else begin
            check("outcome", {27'd0, done, err, cpu_run, err_code}, {27'd0, 3'b010, c});
          end
        end
      end
      out_prev = done || err;
    end else begin
      out_prev = 1'b0;
    end
  end

  initial begin
    bq_t q;
    int n;
    int kind;
    int bad_pos;
    logic [1:0] dummy_code;
    int dummy_used;

    #3;
    check("reset_outputs", {21'd0, in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, err_code},
          32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    q = '{8'h03, 8'h05, 8'h2A, 8'h3F}; add_chk(q, 8'h00); run_load(q, 0);
    q = '{8'h00};                      run_load(q, 0);
    q = '{8'h21};                      run_load(q, 0);
    q = '{8'h02, 8'h05, 8'h45};        run_load(q, 0);
`ifdef PROG_LOADER_CHKSUM_EN
    q = '{8'h02, 8'h11, 8'h22, 8'h33}; run_load(q, 0);
    q = '{8'h02, 8'h11, 8'h22, 8'h34}; run_load(q, 0);
`endif

    // 20-word load with random in_valid gaps
    q = '{8'd20};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom_range(0, 63)));
    add_chk(q, 8'h00);
    run_load(q, 3);

    // Full-depth load, back to back, ends at address 31
    q = '{8'd32};
    for (int i = 0; i < 32; i++) q.push_back(8'($urandom_range(0, 63)));
    add_chk(q, 8'h00);
    run_load(q, 0);

    // Reset after the second data byte of a 5-word load
    q = '{8'h05, 8'h01, 8'h02};
    model(q, dummy_used, dummy_code);
    while (wq.size() > 2) wq.pop_back();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(q[i], 0);
    #2 rstn = 1'b0;
    #1;
    check("midload_reset", {21'd0, in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, err_code},
          32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("reset_writes", wq.size(), 0);
    check("reset_idle", {30'd0, in_ready, done}, 32'd0);
    wq.delete();

    q = '{8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D}; add_chk(q, 8'h00); run_load(q, 1);

    // Randomized loads
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        q = '{($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255))};
      end else begin
        n = int'($urandom_range(1, 32));
        q = '{8'(n)};
        bad_pos = (kind == 1) ? int'($urandom_range(1, n)) : 0;
        for (int i = 1; i <= n; i++)
          q.push_back((i == bad_pos) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63)));
        add_chk(q, (kind == 2) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      end
      run_load(q, ($urandom_range(0, 1) == 0) ? 0 : 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_SIZE, default 6: program-memory instruction width in bits.
REQ-002 Parameter ADDR_SIZE, default 5: program-memory address width; depth = 2**ADDR_SIZE = 32.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse requesting a new program load.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 mem_we  output  1  program-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  ADDR_SIZE  program-memory write address.
REQ-011 mem_wdata  output  DATA_SIZE  program-memory write data.
REQ-012 cpu_run  output  1  high releases the CPU core; low holds it in reset/stall.
REQ-013 done  output  1  load completed successfully; sticky until next start.
REQ-014 err  output  1  load aborted; sticky until next start.
REQ-015 err_code  output  2  01 bad length, 10 bad data byte, 11 checksum mismatch, 00 none.

Function
REQ-016 Byte transfer SHALL occur only on a cycle with in_valid && in_ready; in_ready SHALL NOT depend combinationally on in_valid.
REQ-017 States: IDLE, LEN, DATA, CHK, DONE, ERR; in_ready SHALL be 1 exactly in LEN, DATA, CHK.
REQ-018 IDLE/DONE/ERR + start -> LEN next cycle; on that transition done, err, err_code, cpu_run SHALL clear and the word counter SHALL reset to 0.
REQ-019 start SHALL be ignored in LEN, DATA, CHK.
REQ-020 LEN: accepted byte N; 1 <= N <= 32 -> DATA with count N latched; N = 0 or N > 32 -> ERR, err_code 01.
REQ-021 DATA: accepted byte with bits [7:DATA_SIZE] nonzero -> ERR, err_code 10, no write issued.
REQ-022 DATA: valid accepted byte SHALL produce mem_we = 1 on the following cycle only, mem_addr = word index (0 .. N-1), mem_wdata = in_data[DATA_SIZE-1:0].
REQ-023 mem_addr and mem_wdata SHALL hold their last written values when mem_we = 0.
REQ-024 After the N-th data byte: -> CHK if PROG_LOADER_CHKSUM_EN defined, else -> DONE.
REQ-025 DONE: done = 1, cpu_run = 1, asserted on the cycle after the final write strobe (never overlapping mem_we).
REQ-026 ERR: err = 1, cpu_run = 0, memory contents undefined.
REQ-027 Back-to-back bytes (in_valid held high) SHALL be accepted one per cycle with no bubbles.
REQ-028 Word counter SHALL never wrap; address 31 is the last writable address.

Reset
REQ-029 rstn low SHALL immediately force state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_run 0, done 0, err 0, err_code 00.
REQ-030 Reset mid-load SHALL abort with no further write strobes; loader remains in IDLE until start.

Configuration
REQ-031 Macro PROG_LOADER_CHKSUM_EN defined: CHK accepts one byte; XOR of all accepted data bytes (full 8 bits) equals it -> DONE, else -> ERR, err_code 11.
REQ-032 Macro PROG_LOADER_CHKSUM_EN undefined: no CHK state, no checksum register, err_code 11 never produced.

Structure
REQ-033 Shared package salamander_pkg SHALL hold the loader state enum, LOAD_LEN_MAX = 32, and the err_code constants.
REQ-034 Sub-module prog_loader_chk (XOR accumulator with clear/enable) SHALL be instantiated only under PROG_LOADER_CHKSUM_EN.

Verification
REQ-035 start, stream 03,05,2A,3F (no checksum build) -> writes (0,05),(1,2A),(2,3F) on consecutive cycles, then done = 1, cpu_run = 1.
REQ-036 start, length byte 00, and separately 21 -> err = 1, err_code 01, no mem_we pulses.
REQ-037 start, stream 02,05,45 -> one write (0,05), then err = 1, err_code 10, cpu_run = 0.
REQ-038 Checksum build: 02,11,22,33 -> done; 02,11,22,34 -> err_code 11.
REQ-039 rstn pulsed low after second data byte of a 05-length load -> all outputs at reset values, no further mem_we; new start reloads from address 0.
REQ-040 in_valid toggled randomly during 20-word load -> exactly 20 writes, addresses 0..19 in order, data matches.
